lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Multi-cycle load/store unit downstream of decode. Takes Load/Store opcode + funct3 + address/data,
//  runs a req/ack handshake with data memory, and generates byte enables and write-lane replication.
//  Returns sign/zero-extended load data, or an error on bad funct3, misalignment, or timeout.
//  Stalls the core via o_busy.
// PARAMETERS
//  ADDR_W      32   byte-address width
//  MEM_TIMEOUT 255  max cycles in REQ waiting for i_mem_ack before error (>=1)
// PORTS
//  i_clk        in   1       clock, all logic on rising edge
//  i_rst_n      in   1       synchronous active-low reset
//  i_valid      in   1       request strobe from decode, sampled only in IDLE
//  i_opcode     in   7       7'b0000011 Load / 7'b0100011 Store; others ignored
//  i_funct3     in   3       000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_addr       in   ADDR_W  byte address (rs1+imm)
//  i_wdata      in   32      store data (rs2)
//  o_busy       out  1       high in every state except IDLE
//  o_done       out  1       one-cycle completion pulse
//  o_err        out  1       one-cycle error pulse, coincident with o_done
//  o_rdata      out  32      extended load data, valid when o_done && !o_err
//  o_mem_req    out  1       memory request, held until ack
//  o_mem_we     out  1       1 = store
//  o_mem_addr   out  ADDR_W  word-aligned address ({i_addr[ADDR_W-1:2],2'b00})
//  o_mem_wdata  out  32      lane-replicated store data
//  o_mem_be     out  4       byte enables (stores only; 4'b0000 on loads)
//  i_mem_ack    in   1       memory accepted write / read data valid
//  i_mem_rdata  in   32      read word, sampled on i_mem_ack
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops o_mem_req next edge,
//   no o_done.
//  FSM IDLE->REQ->DONE->IDLE; IDLE->ERR->IDLE; REQ->ERR->IDLE.
//  IDLE: on i_valid && Load/Store, latch opcode/funct3/addr/wdata. Then check:
//   illegal funct3 (load 011/110/111, store >=011) -> ERR with no memory access; otherwise -> REQ.
//  REQ: o_mem_req=1 with stable addr/we/be/wdata; counter increments each cycle.
//   i_mem_ack -> capture rdata, go to DONE. Ack in the first REQ cycle is legal (2-cycle op).
//   Counter reaches MEM_TIMEOUT without ack -> ERR; an ack on that same cycle wins.
//  DONE: o_done=1 for 1 cycle. ERR: o_done=1 and o_err=1 for 1 cycle, o_rdata=0.
//  i_valid outside IDLE is ignored (decode must hold the instruction while o_busy).
//  Byte enables: B 4'b0001<<a[1:0]; H 4'b0011<<{a[1],1'b0}; W 4'b1111.
//  o_mem_wdata: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
//  Load extract: B/BU take the byte at a[1:0]; H/HU take the half at a[1]; W takes the full word.
//   B/H sign-extend; BU/HU zero-extend. o_rdata holds until the next o_done.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H/HU with a[0]=1, or W with a[1:0]!=0 -> ERR, no memory access.
//  Undefined: no misalign check; lane selection uses only the bits above (H ignores a[0], W ignores a[1:0]).
// TESTING
//  SW addr 0x100, wdata 0xDEADBEEF, ack after 3 cycles -> be=1111, mem_addr 0x100, o_done 5 cycles after i_valid
//  SB addr 0x103, wdata 0x000000A5 -> be=1000, mem_wdata 0xA5A5A5A5
//  LB addr 0x202, rdata 0x0080FF00 -> o_rdata 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x202 -> 0x00000080
//  No ack, MEM_TIMEOUT=4 -> o_mem_req high 4 cycles, then o_done=o_err=1, o_busy falls next cycle
//  Load funct3=011 -> o_err pulse, o_mem_req never asserted; i_valid pulses while busy -> no extra op
//  LW addr 0x102: with LSU_MISALIGN_TRAP_EN -> o_err, no req; without -> mem_addr 0x100, normal completion

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: req/ack data-memory handshake with byte enables, lane replication and load extension.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors with no memory access.
module lsu_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       rdata_q;

  logic        is_load, is_store, f3_ok, misalign;
  logic        latch_en, cap_en, err_en;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    is_load  = (i_opcode == OP_LOAD);
    is_store = (i_opcode == OP_STORE);

    f3_ok = 1'b0;
    if (is_load)
      f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
              (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
    else if (is_store)
      f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);

`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
               ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    // Lane width comes from funct3[1:0]; the unsigned bit only matters for loads.
    be_in    = 4'b1111;
    wdata_in = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << i_addr[1:0];
        wdata_in = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_in    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!is_store) be_in = 4'b0000;
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = i_mem_rdata[7:0];
      2'b01:   byte_sel = i_mem_rdata[15:8];
      2'b10:   byte_sel = i_mem_rdata[23:16];
      default: byte_sel = i_mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    cap_en    = 1'b0;
    err_en    = 1'b0;
    o_busy    = (state_q != S_IDLE);
    o_done    = (state_q == S_DONE) || (state_q == S_ERR);
    o_err     = (state_q == S_ERR);
    o_mem_req = (state_q == S_REQ);
    case (state_q)
      S_IDLE: begin
        if (i_valid && (is_load || is_store)) begin
          latch_en = 1'b1;
          cnt_d    = '0;
          if (!f3_ok || misalign) begin
            state_d = S_ERR;
            err_en  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A late ack on the final allowed cycle still completes normally.
        if (i_mem_ack) begin
          cap_en  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_en  = 1'b1;
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        store_q  <= is_store;
        funct3_q <= i_funct3;
        addr_q   <= i_addr;
        wdata_q  <= wdata_in;
        be_q     <= be_in;
      end
      if (cap_en)
        rdata_q <= load_ext;
      else if (err_en)
        rdata_q <= '0;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_mem_we    = o_mem_req && store_q;
  assign o_mem_be    = o_mem_req ? be_q : 4'b0000;
  assign o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata = wdata_q;

endmodule
